ldw_alu: RTL and testbench

- 32-bit integer ALU for the pipelined MIPS-subset CPU.
- Instantiated by the EXE stage, which handles operand muxing: shift-amount or register into a, immediate or register into b.
- Computes arithmetic, logic, LUI and shift results selected by a 4-bit op code.
- Registers the result and its zero flag, so outputs are valid one clock after the inputs.

---
 rtl/ldw_pkg.sv | 26 ++
 rtl/ldw_alu_shifter.sv | 24 ++
 rtl/ldw_alu.sv | 82 ++++++++
 tb/tb_ldw_alu.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ldw_pkg.sv
// Shared definitions for the ldw ALU: op codes and the op[1:0] class decode.
package ldw_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   // Operation class selected by op[1:0]; op[2] picks the variant within a class.
   typedef enum logic [1:0] {
      CLS_ARITH = 2'b00,  // ADD / SUB
      CLS_LOGIC = 2'b01,  // AND / OR
      CLS_XLUI  = 2'b10,  // XOR / LUI
      CLS_SHIFT = 2'b11   // SLL / SRL / SRA
   } alu_cls_e;

   function automatic alu_cls_e op_class(input logic [1:0] op_lo);
      return alu_cls_e'(op_lo);
   endfunction

endpackage

// File: rtl/ldw_alu_shifter.sv
// Combinational barrel shifter: SLL, SRL and SRA of b by a 5-bit amount.
// sel is op[3:2]: 01 -> SRL, 11 -> SRA, 00/10 -> SLL.
module ldw_alu_shifter
   import ldw_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       shamt,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] y
);

   // Select the shift direction and fill from op[3:2].
   always_comb begin
      y = b << shamt;
      unique case (sel)
         2'b01:   y = b >> shamt;
         2'b11:   y = WIDTH'($signed(b) >>> shamt);
         default: y = b << shamt;
      endcase
   end

endmodule

// File: rtl/ldw_alu.sv
// 32-bit ALU for the EXE stage: shared add/sub adder, logic ops, LUI and
// shifts, with the result, zero and overflow flags registered together.
module ldw_alu
   import ldw_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] r,
   output logic             z,
   output logic             v
);

   logic [WIDTH-1:0] r_d, r_q;
   logic             z_d, z_q;
   logic             v_d, v_q;

   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;
   logic             ovf;
   logic [WIDTH-1:0] shift_y;
   alu_cls_e         cls;

   ldw_alu_shifter #(
      .WIDTH (WIDTH)
   ) u_shifter (
      .b     (b),
      .shamt (a[4:0]),
      .sel   (op[3:2]),
      .y     (shift_y)
   );

   // Single adder: SUB inverts b and injects a carry-in of one.
   // Overflow reduces to one test on a and the effective b for both ops.
   always_comb begin
      sub   = op[2];
      b_eff = sub ? ~b : b;
      sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
      ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

   // Result mux, zero flag and overflow gating; every op code is defined.
   always_comb begin
      cls = op_class(op[1:0]);
      r_d = '0;
      v_d = 1'b0;
      unique case (cls)
         CLS_ARITH: begin
            r_d = sum;
            v_d = ovf;
         end
         CLS_LOGIC: r_d = op[2] ? (a | b) : (a & b);
         CLS_XLUI:  r_d = op[2] ? {b[15:0], 16'h0000} : (a ^ b);
         CLS_SHIFT: r_d = shift_y;
         default:   r_d = '0;
      endcase
      z_d = (r_d == '0);
   end

   // Output registers; reset overrides the computed result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
         z_q <= 1'b1;
         v_q <= 1'b0;
      end else begin
         r_q <= r_d;
         z_q <= z_d;
         v_q <= v_d;
      end
   end

   assign r = r_q;
   assign z = z_q;
   assign v = v_q;

endmodule

// File: tb/tb_ldw_alu.sv
// Directed, table-driven bench for ldw_alu.
module tb_ldw_alu;
   import ldw_pkg::*;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] r;
      logic        z;
      logic        v;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b;
   logic [3:0]  op;
   logic [31:0] r;
   logic        z, v;

   int checks = 0;
   int errors = 0;

   vec_t tv[$];

   ldw_alu #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .op  (op),
      .r   (r),
      .z   (z),
      .v   (v)
   );

   always #5 clk = ~clk;

   task automatic expect_out(input string name, input logic [31:0] er,
                             input logic ez, input logic ev);
      checks++;
      if ({r, z, v} !== {er, ez, ev}) begin
         errors++;
         $display("FAIL %s: got r=%h z=%b v=%b, want r=%h z=%b v=%b",
                  name, r, z, v, er, ez, ev);
      end
   endtask

   task automatic drive(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [3:0] top, input logic trst);
      @(negedge clk);
      a   = ta;
      b   = tb_;
      op  = top;
      rst = trst;
   endtask

   task automatic add_vec(input logic [31:0] ta, input logic [31:0] tb_,
                          input logic [3:0] top, input logic [31:0] er,
                          input logic ez, input logic ev);
      vec_t t;
      t.a = ta; t.b = tb_; t.op = top; t.r = er; t.z = ez; t.v = ev;
      tv.push_back(t);
   endtask

   initial begin
      logic [31:0] prev_r;
      logic        prev_z, prev_v;

      // Directed vectors
      add_vec(32'h7FFFFFFF, 32'h00000001, ALU_ADD, 32'h80000000, 1'b0, 1'b1);
      add_vec(32'h80000000, 32'h00000001, ALU_SUB, 32'h7FFFFFFF, 1'b0, 1'b1);
      add_vec(32'h00000005, 32'h00000005, 4'b1100, 32'h00000000, 1'b1, 1'b0);
      add_vec(32'hF0F0F0F0, 32'h0FF00FF0, ALU_AND, 32'h00F000F0, 1'b0, 1'b0);
      add_vec(32'hF0F0F0F0, 32'h0FF00FF0, ALU_OR,  32'hFFF0FFF0, 1'b0, 1'b0);
      add_vec(32'hF0F0F0F0, 32'h0FF00FF0, ALU_XOR, 32'hFF00FF00, 1'b0, 1'b0);
      add_vec(32'hF0F0F0F0, 32'h00001234, ALU_LUI, 32'h12340000, 1'b0, 1'b0);
      add_vec(32'h00000004, 32'h80000001, ALU_SLL, 32'h00000010, 1'b0, 1'b0);
      add_vec(32'h00000004, 32'h80000001, ALU_SRL, 32'h08000000, 1'b0, 1'b0);
      add_vec(32'h00000004, 32'h80000001, ALU_SRA, 32'hF8000000, 1'b0, 1'b0);
      add_vec(32'hFFFFFFE0, 32'h80000001, ALU_SRA, 32'h80000001, 1'b0, 1'b0);
      add_vec(32'h0000001F, 32'h80000001, ALU_SRL, 32'h00000001, 1'b0, 1'b0);
      add_vec(32'h0000001F, 32'h80000001, ALU_SLL, 32'h80000000, 1'b0, 1'b0);
      add_vec(32'h0000001F, 32'h80000001, ALU_SRA, 32'hFFFFFFFF, 1'b0, 1'b0);
      // All 16 op codes, a=0x104 (shift amount 4), b=0x80000F01
      add_vec(32'h00000104, 32'h80000F01, 4'b0000, 32'h80001005, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b0001, 32'h00000100, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b0010, 32'h80000E05, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b0011, 32'h0000F010, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b0100, 32'h7FFFF203, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b0101, 32'h80000F05, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b0110, 32'h0F010000, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b0111, 32'h080000F0, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b1000, 32'h80001005, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b1001, 32'h00000100, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b1010, 32'h80000E05, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b1011, 32'h0000F010, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b1100, 32'h7FFFF203, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b1101, 32'h80000F05, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b1110, 32'h0F010000, 1'b0, 1'b0);
      add_vec(32'h00000104, 32'h80000F01, 4'b1111, 32'hF80000F0, 1'b0, 1'b0);

      // Reset held for two edges with live inputs
      rst = 1'b1; a = 32'd5; b = 32'd7; op = ALU_ADD;
      @(posedge clk); #1;
      expect_out("reset_edge1", 32'h0, 1'b1, 1'b0);
      @(posedge clk); #1;
      expect_out("reset_edge2", 32'h0, 1'b1, 1'b0);
      drive(32'd5, 32'd7, ALU_ADD, 1'b0);
      @(posedge clk); #1;
      expect_out("reset_release", 32'd12, 1'b0, 1'b0);
      prev_r = 32'd12; prev_z = 1'b0; prev_v = 1'b0;

      // Back-to-back table: each result one edge after its inputs, held until then
      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].a, tv[i].b, tv[i].op, 1'b0);
         #1;
         expect_out($sformatf("hold_%0d", i), prev_r, prev_z, prev_v);
         @(posedge clk); #1;
         expect_out($sformatf("vec_%0d_op%b", i, tv[i].op), tv[i].r, tv[i].z, tv[i].v);
         prev_r = tv[i].r; prev_z = tv[i].z; prev_v = tv[i].v;
      end

      // Back-to-back ADD, SUB, XOR
      drive(32'd100, 32'd23, ALU_ADD, 1'b0);
      @(posedge clk); #1;
      expect_out("seq_add", 32'd123, 1'b0, 1'b0);
      drive(32'd100, 32'd123, ALU_SUB, 1'b0);
      #1;
      expect_out("seq_sub_hold", 32'd123, 1'b0, 1'b0);
      @(posedge clk); #1;
      expect_out("seq_sub", 32'hFFFFFFE9, 1'b0, 1'b0);
      drive(32'h0000FFFF, 32'h0000FFFF, ALU_XOR, 1'b0);
      @(posedge clk); #1;
      expect_out("seq_xor", 32'h0, 1'b1, 1'b0);

      // Mid-stream reset pulse discards the in-flight ADD
      drive(32'd1, 32'd2, ALU_ADD, 1'b0);
      @(posedge clk); #1;
      expect_out("mid_add1", 32'd3, 1'b0, 1'b0);
      drive(32'h7FFFFFFF, 32'd1, ALU_ADD, 1'b1);
      @(posedge clk); #1;
      expect_out("mid_reset", 32'h0, 1'b1, 1'b0);
      drive(32'd7, 32'd8, ALU_ADD, 1'b0);
      @(posedge clk); #1;
      expect_out("mid_add2", 32'd15, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
